sync_barrier_ctrl: RTL and testbench

Central synchronization responder for a multi-core array of distributed processors. Each core raises its sync request and drives a barrier ID, then stalls while its sync instruction is current. This block tracks which cores have arrived at each barrier. It holds them until every member core in that barrier's programmed participant mask has arrived, then releases all members with a one-cycle `sync_enable` pulse that advances their instruction pointers.

---
 rtl/sync_barrier_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sync_barrier_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_barrier_ctrl.sv
// sync_barrier_ctrl
// Central barrier responder for a multi-core array. Each core raises
// sync_req with a barrier ID and is held in WAIT until every member of that
// barrier's participant mask has arrived. All members are then released
// together with a one-cycle sync_enable strobe.
//
// Ports:
//   clk          system clock (single domain)
//   reset_n      asynchronous active-low reset
//   sync_req     per-core level request, high while the sync instruction is current
//   sync_id      packed per-core barrier IDs, core i at [i*SYNC_BARRIER_WIDTH +: SYNC_BARRIER_WIDTH]
//   sync_enable  per-core one-cycle release strobe (registered)
//   cfg_we       participant-mask write enable
//   cfg_addr     barrier index for the mask write
//   cfg_mask     participant mask, bit i = core i is a member
//   waiting      core i is held at a barrier (registered)
//   barrier_done one-cycle pulse per barrier on release (registered)
//   err_id       sticky flag for invalid arrivals (registered)
//   err_clr      clears err_id; a simultaneous set wins
module sync_barrier_ctrl #(
    parameter int NUM_CORES          = 4,
    parameter int SYNC_BARRIER_WIDTH = 8,
    parameter int BAR_ADDR_WIDTH     = 2,
    localparam int NUM_BARRIERS      = 2 ** BAR_ADDR_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [NUM_CORES-1:0]                    sync_req,
    input  logic [NUM_CORES*SYNC_BARRIER_WIDTH-1:0] sync_id,
    output logic [NUM_CORES-1:0]                    sync_enable,
    input  logic                                    cfg_we,
    input  logic [BAR_ADDR_WIDTH-1:0]               cfg_addr,
    input  logic [NUM_CORES-1:0]                    cfg_mask,
    output logic [NUM_CORES-1:0]                    waiting,
    output logic [NUM_BARRIERS-1:0]                 barrier_done,
    output logic                                    err_id,
    input  logic                                    err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                    state_r      [NUM_CORES];
    state_t                    next_state_s [NUM_CORES];
    logic [BAR_ADDR_WIDTH-1:0] id_r         [NUM_CORES];
    logic [BAR_ADDR_WIDTH-1:0] id_next_s    [NUM_CORES];
    logic [NUM_CORES-1:0]      mask_r       [NUM_BARRIERS];
    logic [NUM_CORES-1:0]      arrived_s    [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0]   complete_s;
    logic [NUM_CORES-1:0]      valid_s;
    logic [NUM_CORES-1:0]      release_s;
    logic [NUM_CORES-1:0]      err_set_s;
    logic [NUM_CORES-1:0]      sync_enable_next_s;
    logic [NUM_CORES-1:0]      waiting_next_s;
    logic                      err_next_s;

    // Arrival validity: upper ID bits must be zero and the core must be a member
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if ((sync_id[i*SYNC_BARRIER_WIDTH +: SYNC_BARRIER_WIDTH] >> BAR_ADDR_WIDTH)
                    == {SYNC_BARRIER_WIDTH{1'b0}}) begin
                valid_s[i] = mask_r[sync_id[i*SYNC_BARRIER_WIDTH +: BAR_ADDR_WIDTH]][i];
            end else begin
                valid_s[i] = 1'b0;
            end
        end
    end

    // Barrier completion from current (pre-write) masks and waiting cores
    always_comb begin
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            for (int j = 0; j < NUM_CORES; j++) begin
                arrived_s[b][j] = (state_r[j] == ST_WAIT) && (id_r[j] == BAR_ADDR_WIDTH'(b));
            end
            complete_s[b] = (mask_r[b] != {NUM_CORES{1'b0}}) &&
                            ((mask_r[b] & ~arrived_s[b]) == {NUM_CORES{1'b0}});
        end
    end

    // A waiting core leaves only if its barrier completes and it is still a member
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            release_s[i] = (state_r[i] == ST_WAIT) && complete_s[id_r[i]] && mask_r[id_r[i]][i];
        end
    end

    // Per-core next-state logic
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            next_state_s[i] = state_r[i];
            id_next_s[i]    = id_r[i];
            err_set_s[i]    = 1'b0;
            case (state_r[i])
                ST_IDLE: begin
                    if (sync_req[i]) begin
                        if (valid_s[i]) begin
                            next_state_s[i] = ST_WAIT;
                            id_next_s[i]    = sync_id[i*SYNC_BARRIER_WIDTH +: BAR_ADDR_WIDTH];
                        end else begin
                            // Invalid ID: release at once so the core cannot deadlock
                            next_state_s[i] = ST_RELEASE;
                            err_set_s[i]    = 1'b1;
                        end
                    end else begin
                        next_state_s[i] = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (release_s[i]) begin
                        next_state_s[i] = ST_RELEASE;
                    end else begin
                        next_state_s[i] = ST_WAIT;
                    end
                end
                // sync_req is ignored here: the core has not advanced yet
                ST_RELEASE: next_state_s[i] = ST_IDLE;
                default:    next_state_s[i] = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            sync_enable_next_s[i] = (next_state_s[i] == ST_RELEASE);
            waiting_next_s[i]     = (next_state_s[i] == ST_WAIT);
        end
        if (err_set_s != {NUM_CORES{1'b0}}) begin
            err_next_s = 1'b1;
        end else if (err_clr) begin
            err_next_s = 1'b0;
        end else begin
            err_next_s = err_id;
        end
    end

    // Per-core state and latched barrier index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                state_r[i] <= ST_IDLE;
                id_r[i]    <= {BAR_ADDR_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                state_r[i] <= next_state_s[i];
                id_r[i]    <= id_next_s[i];
            end
        end
    end

    // Participant masks; reset to all-ones so every core belongs everywhere
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                mask_r[b] <= {NUM_CORES{1'b1}};
            end
        end else if (cfg_we) begin
            mask_r[cfg_addr] <= cfg_mask;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_enable  <= {NUM_CORES{1'b0}};
            waiting      <= {NUM_CORES{1'b0}};
            barrier_done <= {NUM_BARRIERS{1'b0}};
            err_id       <= 1'b0;
        end else begin
            sync_enable  <= sync_enable_next_s;
            waiting      <= waiting_next_s;
            barrier_done <= complete_s;
            err_id       <= err_next_s;
        end
    end

endmodule

// File: tb/tb_sync_barrier_ctrl.sv
// Directed scoreboard bench for sync_barrier_ctrl. Expected output vectors
// are queued with the cycle at which they must appear and compared when the
// bench reaches that cycle (sampled 1 ns after the rising edge).
module tb_sync_barrier_ctrl;

    localparam int NC = 4;
    localparam int SW = 8;
    localparam int BA = 2;
    localparam int NB = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NC-1:0]    sync_req;
    logic [NC*SW-1:0] sync_id;
    logic [NC-1:0]    sync_enable;
    logic             cfg_we;
    logic [BA-1:0]    cfg_addr;
    logic [NC-1:0]    cfg_mask;
    logic [NC-1:0]    waiting;
    logic [NB-1:0]    barrier_done;
    logic             err_id;
    logic             err_clr;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] wt;
        logic [3:0] en;
        logic [3:0] bd;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   base   = 0;

    always #5 clk = ~clk;

    sync_barrier_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sync_req     (sync_req),
        .sync_id      (sync_id),
        .sync_enable  (sync_enable),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_mask     (cfg_mask),
        .waiting      (waiting),
        .barrier_done (barrier_done),
        .err_id       (err_id),
        .err_clr      (err_clr)
    );

    task automatic cmp4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cmp1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input int at, input string tag, input logic [3:0] wt,
                        input logic [3:0] en, input logic [3:0] bd, input logic err);
        exp_t e;
        e.cyc = at; e.tag = tag; e.wt = wt; e.en = en; e.bd = bd; e.err = err;
        sb.push_back(e);
    endtask

    task automatic check_due();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            cmp4({e.tag, ".waiting"},      waiting,      e.wt);
            cmp4({e.tag, ".sync_enable"},  sync_enable,  e.en);
            cmp4({e.tag, ".barrier_done"}, barrier_done, e.bd);
            cmp1({e.tag, ".err_id"},       err_id,       e.err);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic set_id(input int core, input logic [7:0] id);
        sync_id[core*SW +: SW] = id;
    endtask

    task automatic cfg(input logic [1:0] addr, input logic [3:0] mask);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_mask = mask;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        sync_req = 4'b0000;
        sync_id  = 32'h0;
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_mask = 4'b0000;
        err_clr  = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk);
        #1;
        cmp4({tag, ".rst_waiting"},      waiting,      4'b0000);
        cmp4({tag, ".rst_sync_enable"},  sync_enable,  4'b0000);
        cmp4({tag, ".rst_barrier_done"}, barrier_done, 4'b0000);
        cmp1({tag, ".rst_err_id"},       err_id,       1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        // A: default masks, all cores arrive at barrier 0 together
        do_reset("A");
        base = cyc;
        sync_req = 4'hF;
        push(base + 1, "A_wait", 4'hF,    4'h0,    4'b0000, 1'b0);
        push(base + 2, "A_rel",  4'h0,    4'hF,    4'b0001, 1'b0);
        push(base + 3, "A_idle", 4'h0,    4'h0,    4'b0000, 1'b0);
        tick(); tick();
        sync_req = 4'h0;
        tick();

        // B: mask 1 = 0101, core 0 held until core 2 arrives
        do_reset("B");
        cfg(2'd1, 4'b0101);
        base = cyc;
        set_id(0, 8'd1);
        sync_req = 4'b0001;
        push(base + 1,  "B_hold",  4'b0001, 4'b0000, 4'b0000, 1'b0);
        push(base + 10, "B_hold2", 4'b0001, 4'b0000, 4'b0000, 1'b0);
        push(base + 16, "B_both",  4'b0101, 4'b0000, 4'b0000, 1'b0);
        push(base + 17, "B_rel",   4'b0000, 4'b0101, 4'b0010, 1'b0);
        push(base + 18, "B_idle",  4'b0000, 4'b0000, 4'b0000, 1'b0);
        repeat (15) tick();
        set_id(2, 8'd1);
        sync_req = 4'b0101;
        tick(); tick();
        sync_req = 4'b0000;
        tick();

        // C: invalid IDs, sticky error, clear, and set-over-clear
        do_reset("C");
        base = cyc;
        set_id(3, 8'h10);
        sync_req = 4'b1000;
        push(base + 1, "C_inv",    4'b0000, 4'b1000, 4'b0000, 1'b1);
        push(base + 2, "C_sticky", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        push(base + 4, "C_hold",   4'b0000, 4'b0000, 4'b0000, 1'b1);
        push(base + 5, "C_clr",    4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        sync_req = 4'b0000;
        tick(); tick(); tick();
        err_clr = 1'b1;
        tick();
        set_id(3, 8'hFF);
        sync_req = 4'b1000;
        push(base + 6, "C_setwin", 4'b0000, 4'b1000, 4'b0000, 1'b1);
        push(base + 7, "C_after",  4'b0000, 4'b0000, 4'b0000, 1'b1);
        tick();
        err_clr  = 1'b0;
        sync_req = 4'b0000;
        tick();
        err_clr = 1'b1;
        push(base + 8, "C_clr2", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        cfg(2'd2, 4'b0001);
        err_clr = 1'b0;
        set_id(1, 8'd2);
        sync_req = 4'b0010;
        push(base + 9,  "C_nonmember", 4'b0000, 4'b0010, 4'b0000, 1'b1);
        push(base + 10, "C_nm_after",  4'b0000, 4'b0000, 4'b0000, 1'b1);
        tick();
        sync_req = 4'b0000;
        tick();

        // D: two barriers completing in the same cycle
        do_reset("D");
        cfg(2'd0, 4'b0011);
        cfg(2'd2, 4'b1100);
        base = cyc;
        sync_id  = {8'd2, 8'd2, 8'd0, 8'd0};
        sync_req = 4'hF;
        push(base + 1, "D_wait", 4'hF, 4'h0, 4'b0000, 1'b0);
        push(base + 2, "D_rel",  4'h0, 4'hF, 4'b0101, 1'b0);
        push(base + 3, "D_idle", 4'h0, 4'h0, 4'b0000, 1'b0);
        tick(); tick();
        sync_req = 4'h0;
        tick();

        // E: asynchronous reset while three cores wait on barrier 0
        do_reset("E");
        cfg(2'd1, 4'b0001);
        base = cyc;
        sync_id  = 32'h0;
        sync_req = 4'b0111;
        push(base + 1, "E_wait1", 4'b0111, 4'b0000, 4'b0000, 1'b0);
        push(base + 2, "E_wait2", 4'b0111, 4'b0000, 4'b0000, 1'b0);
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        cmp4("E_async.waiting",      waiting,      4'b0000);
        cmp4("E_async.sync_enable",  sync_enable,  4'b0000);
        cmp4("E_async.barrier_done", barrier_done, 4'b0000);
        cmp1("E_async.err_id",       err_id,       1'b0);
        #2 reset_n = 1'b1;
        push(base + 3, "E_rearrive", 4'b0111, 4'b0000, 4'b0000, 1'b0);
        tick();
        sync_req = 4'hF;
        push(base + 4, "E_all",  4'hF, 4'h0, 4'b0000, 1'b0);
        push(base + 5, "E_rel",  4'h0, 4'hF, 4'b0001, 1'b0);
        push(base + 6, "E_idle", 4'h0, 4'h0, 4'b0000, 1'b0);
        tick(); tick();
        sync_req = 4'h0;
        tick();
        // Mask 1 was 0001 before reset; after reset core 2 is a member again
        set_id(2, 8'd1);
        sync_req = 4'b0100;
        push(base + 7, "E_maskrst", 4'b0100, 4'b0000, 4'b0000, 1'b0);
        tick();
        sync_req = 4'b0000;

        // F: mask write in the same cycle as the last arrival
        do_reset("F");
        base = cyc;
        sync_id  = 32'h0;
        sync_req = 4'b0001;
        push(base + 1, "F_c0wait", 4'b0001, 4'b0000, 4'b0000, 1'b0);
        tick();
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_mask = 4'b0011;
        sync_req = 4'b0011;
        push(base + 2, "F_norel", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        push(base + 3, "F_rel",   4'b0000, 4'b0011, 4'b0001, 1'b0);
        push(base + 4, "F_idle",  4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        cfg_we = 1'b0;
        tick();
        sync_req = 4'b0000;
        tick();

        // Any expectation not yet reached is a failure
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            tick();
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
